// File: rtl/pcpu_memsys_pkg.sv
// rtl/pcpu_memsys_pkg.sv - shared state encoding, header fields and default widths
package pcpu_memsys_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;

    localparam int TGT_BIT = 15;
    localparam int GO_BIT  = 14;
    localparam int CNT_MSB = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_BASE,
        ST_DATA,
        ST_GO,
        ST_RUN
    } state_e;

endpackage

// File: rtl/pcpu_ram.sv
// rtl/pcpu_ram.sv - single-port-write, async-read word memory
module pcpu_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pcpu_memsys.sv
// rtl/pcpu_memsys.sv - IMEM/DMEM pair with host block loader and CPU run control
module pcpu_memsys
    import pcpu_memsys_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_datain,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_dataout,
    input  logic              d_we,
    output logic [DATA_W-1:0] d_datain,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              enable,
    output logic              start,
    output logic              busy,
    output logic              wr_conflict
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_MSB:0]   cnt_q, cnt_d;
    logic               tgt_q, tgt_d;
    logic               go_q, go_d;
    logic               wr_conflict_q;
    logic               ld_we;
    logic               imem_we, dmem_we;
    logic [ADDR_W-1:0]  dmem_waddr;
    logic [DATA_W-1:0]  dmem_wdata;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        tgt_d    = tgt_q;
        go_d     = go_q;
        ld_ready = 1'b0;
        enable   = 1'b0;
        start    = 1'b0;
        ld_we    = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                ld_ready = 1'b1;
                enable   = (state_q == ST_RUN);
                if (ld_valid) begin
                    tgt_d   = ld_data[TGT_BIT];
                    go_d    = ld_data[GO_BIT];
                    cnt_d   = ld_data[CNT_MSB:0];
                    // a header arriving while the CPU runs passes through HDR so enable drops first
                    state_d = (state_q == ST_RUN) ? ST_HDR : ST_BASE;
                end
            end
            ST_HDR: begin
                state_d = ST_BASE;
            end
            ST_BASE: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    ptr_d   = ld_data[ADDR_W-1:0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    ld_we = 1'b1;
                    ptr_d = ptr_q + 1'b1;
                    if (cnt_q == '0) begin
                        state_d = go_q ? ST_GO : ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            ST_GO: begin
                start   = 1'b1;
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            tgt_q         <= 1'b0;
            go_q          <= 1'b0;
            wr_conflict_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            go_q    <= go_d;
            if (d_we && !enable) begin
                wr_conflict_q <= 1'b1;
            end
        end
    end

    // Loader and CPU never write DMEM together: the CPU path is live only in RUN
    assign imem_we    = !reset && ld_we && !tgt_q;
    assign dmem_we    = !reset && ((ld_we && tgt_q) || (d_we && enable));
    assign dmem_waddr = enable ? d_addr : ptr_q;
    assign dmem_wdata = enable ? d_dataout : ld_data;

    assign busy        = (state_q != ST_IDLE) && (state_q != ST_RUN);
    assign wr_conflict = wr_conflict_q;

    pcpu_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_imem (
        .clk_i   (clock),
        .we_i    (imem_we),
        .waddr_i (ptr_q),
        .wdata_i (ld_data),
        .raddr_i (i_addr),
        .rdata_o (i_datain)
    );

    pcpu_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dmem (
        .clk_i   (clock),
        .we_i    (dmem_we),
        .waddr_i (dmem_waddr),
        .wdata_i (dmem_wdata),
        .raddr_i (d_addr),
        .rdata_o (d_datain)
    );

endmodule

// File: tb/tb_pcpu_memsys.sv
// tb/tb_pcpu_memsys.sv - scoreboard bench for pcpu_memsys with a transaction-level memory model
module tb_pcpu_memsys;

    localparam int K_I = 0, K_D = 1, K_RDY = 2, K_EN = 3, K_ST = 4, K_BUSY = 5, K_WC = 6;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  i_addr, d_addr;
    logic [15:0] i_datain, d_datain, d_dataout, ld_data;
    logic        d_we, ld_valid, ld_ready, enable, start, busy, wr_conflict;

    pcpu_memsys dut (
        .clock       (clock),
        .reset       (reset),
        .i_addr      (i_addr),
        .i_datain    (i_datain),
        .d_addr      (d_addr),
        .d_dataout   (d_dataout),
        .d_we        (d_we),
        .d_datain    (d_datain),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .enable      (enable),
        .start       (start),
        .busy        (busy),
        .wr_conflict (wr_conflict)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          kind;
        logic [15:0] exp;
        int          step;
    } chk_t;

    chk_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          step = 0;
    logic [15:0] imem_m[256], dmem_m[256];
    bit          ik[256], dk[256];
    logic [15:0] wbuf[256];
    logic [5:0]  hdr_mid;
    bit          in_run;
    bit          wc_m;

    function automatic string kname(input int k);
        case (k)
            K_I:     return "i_datain";
            K_D:     return "d_datain";
            K_RDY:   return "ld_ready";
            K_EN:    return "enable";
            K_ST:    return "start";
            K_BUSY:  return "busy";
            default: return "wr_conflict";
        endcase
    endfunction

    function automatic logic [15:0] actual(input int k);
        case (k)
            K_I:     return i_datain;
            K_D:     return d_datain;
            K_RDY:   return {15'd0, ld_ready};
            K_EN:    return {15'd0, enable};
            K_ST:    return {15'd0, start};
            K_BUSY:  return {15'd0, busy};
            default: return {15'd0, wr_conflict};
        endcase
    endfunction

    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            chk_t c;
            logic [15:0] a;
            c = exp_q.pop_front();
            a = actual(c.kind);
            checks++;
            if (a !== c.exp) begin
                failures++;
                $display("FAIL %s step=%0d actual=%h required=%h", kname(c.kind), c.step, a, c.exp);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        step++;
    endtask

    task automatic expect_o(input int k, input logic [15:0] v);
        chk_t c;
        c.kind = k;
        c.exp  = v;
        c.step = step;
        exp_q.push_back(c);
    endtask

    task automatic status(input bit rdy, input bit en, input bit st, input bit bz);
        expect_o(K_RDY, {15'd0, rdy});
        expect_o(K_EN, {15'd0, en});
        expect_o(K_ST, {15'd0, st});
        expect_o(K_BUSY, {15'd0, bz});
    endtask

    // mode 0: back-to-back, 1: random gaps, 2: strict 0/1 valid toggling
    task automatic send_word(input logic [15:0] w, input int mode);
        int g;
        g = (mode == 1) ? int'($urandom_range(0, 2)) : ((mode == 2) ? 1 : 0);
        repeat (g) begin
            ld_valid = 1'b0;
            ld_data  = 16'($urandom);
            tick();
        end
        ld_valid = 1'b1;
        ld_data  = w;
        tick();
        ld_valid = 1'b0;
        ld_data  = 16'($urandom);
    endtask

    task automatic load(input bit tgt, input bit go, input logic [7:0] base, input int n,
                        input int mode, input bit conflict, input int abort_at);
        logic [7:0] a;
        if (in_run) status(1, 1, 0, 0);
        else        status(1, 0, 0, 0);
        send_word({tgt, go, hdr_mid, 8'(n - 1)}, mode);
        if (in_run) begin
            status(0, 0, 0, 1);
            ld_valid = 1'b1;
            ld_data  = 16'($urandom);
            tick();
            ld_valid = 1'b0;
            in_run   = 1'b0;
        end
        status(1, 0, 0, 1);
        if (conflict) begin
            d_we      = 1'b1;
            d_addr    = 8'h05;
            d_dataout = 16'hBEEF;
            tick();
            d_we = 1'b0;
            wc_m = 1'b1;
            expect_o(K_WC, 16'd1);
        end
        send_word({8'($urandom), base}, mode);
        for (int i = 0; i < n; i++) begin
            status(1, 0, 0, 1);
            if (i == abort_at) begin
                reset    = 1'b1;
                ld_valid = 1'b1;
                ld_data  = wbuf[i];
                d_we     = 1'b1;
                tick();
                reset    = 1'b0;
                ld_valid = 1'b0;
                d_we     = 1'b0;
                wc_m     = 1'b0;
                status(1, 0, 0, 0);
                expect_o(K_WC, 16'd0);
                return;
            end
            send_word(wbuf[i], mode);
            a = 8'((int'(base) + i) % 256);
            if (tgt) begin dmem_m[a] = wbuf[i]; dk[a] = 1'b1; end
            else     begin imem_m[a] = wbuf[i]; ik[a] = 1'b1; end
            if (i < n - 1) expect_o(K_ST, 16'd0);
        end
        if (go) begin
            status(0, 0, 1, 1);
            tick();
            status(1, 1, 0, 0);
            in_run = 1'b1;
        end else begin
            status(1, 0, 0, 0);
        end
        expect_o(K_WC, {15'd0, wc_m});
    endtask

    task automatic verify_range(input bit tgt, input logic [7:0] first, input int cnt);
        logic [7:0] a;
        for (int i = 0; i < cnt; i++) begin
            a = 8'((int'(first) + i) % 256);
            if (tgt && dk[a]) begin
                d_addr = a;
                expect_o(K_D, dmem_m[a]);
                tick();
            end else if (!tgt && ik[a]) begin
                i_addr = a;
                expect_o(K_I, imem_m[a]);
                tick();
            end
        end
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) wbuf[i] = 16'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog step=%0d actual=timeout required=finish", step);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        logic [7:0] ra;
        logic [15:0] rd;
        int n;
        reset = 1'b1; ld_valid = 1'b0; ld_data = '0; d_we = 1'b0;
        d_addr = '0; d_dataout = '0; i_addr = '0;
        hdr_mid = '0; in_run = 1'b0; wc_m = 1'b0;
        for (int i = 0; i < 256; i++) begin ik[i] = 1'b0; dk[i] = 1'b0; end
        tick();
        tick();
        status(1, 0, 0, 0);
        expect_o(K_WC, 16'd0);
        reset = 1'b0;
        tick();
        status(1, 0, 0, 0);

        // Preload DMEM 0x00..0x3F so later "unchanged" checks have known contents
        fill_random(64);
        load(1, 0, 8'h00, 64, 1, 0, -1);
        verify_range(1, 8'h00, 64);

        wbuf[0] = 16'h1111; wbuf[1] = 16'h2222;
        load(1, 0, 8'hFF, 2, 0, 0, -1);
        verify_range(1, 8'hFE, 3);

        fill_random(4);
        load(1, 0, 8'h30, 4, 2, 0, -1);
        verify_range(1, 8'h2F, 6);

        fill_random(3);
        load(1, 0, 8'h08, 3, 0, 0, 1);
        verify_range(1, 8'h07, 5);

        fill_random(3);
        load(1, 0, 8'h40, 3, 1, 1, -1);
        verify_range(1, 8'h05, 1);
        verify_range(1, 8'h40, 3);

        wbuf[0] = 16'hAAAA; wbuf[1] = 16'hBBBB; wbuf[2] = 16'hCCCC;
        load(0, 1, 8'h10, 3, 0, 0, -1);
        verify_range(0, 8'h10, 3);

        // Store and read the same word in one RUN cycle
        d_addr = 8'h20; d_dataout = 16'h1234; d_we = 1'b1;
        expect_o(K_D, dmem_m[8'h20]);
        tick();
        dmem_m[8'h20] = 16'h1234;
        d_we = 1'b0;
        expect_o(K_D, 16'h1234);
        expect_o(K_EN, 16'd1);
        tick();

        for (int i = 0; i < 12; i++) begin
            ra = 8'($urandom);
            rd = 16'($urandom);
            d_addr = ra; d_dataout = rd; d_we = 1'b1;
            tick();
            dmem_m[ra] = rd; dk[ra] = 1'b1;
            d_we = 1'b0;
            expect_o(K_D, rd);
            tick();
        end

        hdr_mid = 6'($urandom);
        fill_random(5);
        load(0, 0, 8'h80, 5, 1, 0, -1);
        verify_range(0, 8'h7F, 7);

        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 8));
            hdr_mid = 6'($urandom);
            fill_random(n);
            ra = 8'($urandom);
            load(1'($urandom), 1'($urandom), ra, n, 1, 0, -1);
            verify_range(1, ra - 8'd1, n + 2);
            verify_range(0, ra - 8'd1, n + 2);
        end

        expect_o(K_WC, 16'd1);
        tick();
        tick();
        checks++;
        if (wr_conflict !== 1'b1) begin
            failures++;
            $display("FAIL wr_conflict step=%0d actual=%b required=1", step, wr_conflict);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy step=%0d actual=%b required=0", step, busy);
        end
        checks++;
        if (ld_ready !== 1'b1) begin
            failures++;
            $display("FAIL ld_ready step=%0d actual=%b required=1", step, ld_ready);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
